// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, single-outstanding variable-latency
// memory requests, and a first-word fall-through queue of {instruction, pc+4}.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            startAddress,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirectAddr,
    output logic                         imemReq,
    output logic [ADDR_W-1:0]            imemAddr,
    input  logic                         imemValid,
    input  logic [INSTR_W-1:0]           imemData,
    output logic                         instValid,
    input  logic                         instReady,
    output logic [INSTR_W-1:0]           instruction,
    output logic [ADDR_W-1:0]            pcPlus4,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SQUASH = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [INSTR_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0]  pc4_q [DEPTH];
    logic [ADDR_W-1:0]  pc4_d [DEPTH];

    logic               req;
    logic               flush;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign req      = (state_q == ST_REQ) && (count_q < CW'(DEPTH)) && !redirect && !start;
    // start acts as a redirect from any state, including IDLE
    assign flush    = start || (redirect && (state_q != ST_IDLE));
    assign push     = (state_q == ST_WAIT) && imemValid && !flush;
    assign pop      = (count_q != '0) && instReady && !flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;

        if (flush) begin
            pc_d    = start ? startAddress : redirectAddr;
            // an outstanding response not yet returned must be swallowed
            state_d = ((state_q == ST_WAIT) && !imemValid) ? ST_SQUASH : ST_REQ;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imemValid) begin
                        pc_d    = pc_plus4;
                        state_d = (imemData == HALT_WORD) ? ST_HALTED : ST_REQ;
                    end
                end
                ST_SQUASH: begin
                    if (imemValid) state_d = ST_REQ;
                end
                default: ;
            endcase

            if (push) begin
                instr_d[tail_q] = imemData;
                pc4_d[tail_q]   = pc_plus4;
                tail_d          = tail_q + PW'(1);
            end
            if (pop) head_d = head_q + PW'(1);

            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    // outputs forced low whenever reset is held, even before the first edge
    assign imemReq     = resetN && req;
    assign imemAddr    = resetN ? pc_q : '0;
    assign instValid   = resetN && (count_q != '0);
    assign instruction = resetN ? instr_q[head_q] : '0;
    assign pcPlus4     = resetN ? pc4_q[head_q] : '0;
    assign halted      = resetN && (state_q == ST_HALTED);
    assign count       = resetN ? count_q : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a cycle table for start/redirect/halt basics, then a
// latency-modelled memory with a scoreboard for the multi-cycle scenarios.
`timescale 1ns/1ps
module tb_fetch_queue;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [31:0] startAddress;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemData;
    logic        instValid;
    logic        instReady;
    logic [31:0] instruction;
    logic [31:0] pcPlus4;
    logic        halted;
    logic [2:0]  count;

    fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .HALT_WORD(32'hFC00_0000)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .startAddress(startAddress),
        .redirect    (redirect),
        .redirectAddr(redirectAddr),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemValid   (imemValid),
        .imemData    (imemData),
        .instValid   (instValid),
        .instReady   (instReady),
        .instruction (instruction),
        .pcPlus4     (pcPlus4),
        .halted      (halted),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          st;
        bit          rd;
        logic [31:0] a;
        bit          vld;
        logic [31:0] data;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [2:0]  e_cnt;
        bit          e_halt;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    logic [31:0] req_log[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_req    = 0;
    int          n_pop    = 0;
    int          lat      = 1;
    int          pend_cnt = 0;
    bit          pend     = 0;
    bit          stale    = 1;
    bit          active   = 0;
    bit          halted_exp = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc    = '0;
    logic [31:0] halt_addr = 32'hDEAD_0000;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit rst, input bit st, input bit rd, input logic [31:0] a,
                                input bit vld, input logic [31:0] data, input bit rdy,
                                input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                                input logic [2:0] e_cnt, input bit e_halt,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_t v;
        v.rst = rst; v.st = st; v.rd = rd; v.a = a; v.vld = vld; v.data = data; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_cnt = e_cnt;
        v.e_halt = e_halt; v.e_instr = e_instr; v.e_pc4 = e_pc4;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == halt_addr) ? 32'hFC00_0000 : {16'h1234, a[15:0]};
    endfunction

    // One clock cycle: memory model, input drive, output checks, reference update.
    task automatic step(input bit rst, input bit st, input logic [31:0] sa,
                        input bit rd, input logic [31:0] ra, input bit rdy);
        bit          vld;
        bit          flush;
        logic [31:0] resp_addr;
        sb_t         e;
        @(negedge clk);
        vld       = 1'b0;
        resp_addr = '0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                vld       = 1'b1;
                resp_addr = pend_addr;
                pend      = 1'b0;
            end
        end
        resetN       = !rst;
        start        = st;
        startAddress = sa;
        redirect     = rd;
        redirectAddr = ra;
        instReady    = rdy;
        imemValid    = vld;
        imemData     = vld ? mem_word(resp_addr) : 32'h0;
        #1;
        flush = 1'b0;
        if (rst) begin
            check("rst_imemReq", imemReq, 0);
            check("rst_instValid", instValid, 0);
            check("rst_count", count, 0);
            check("rst_halted", halted, 0);
        end else begin
            check("count", count, sb.size());
            check("instValid", instValid, sb.size() != 0);
            check("halted", halted, halted_exp);
            if (imemReq) begin
                n_req++;
                req_log.push_back(imemAddr);
                check("req_addr", imemAddr, exp_pc);
                check("req_protocol", pend || vld || halted_exp || st || rd, 0);
            end
            flush = st || (rd && active);
            if (instValid && rdy && !flush) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", instValid, 0);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    check("head_instr", instruction, e.instr);
                    check("head_pc4", pcPlus4, e.pc4);
                end
            end
        end
        if (rst) begin
            sb.delete();
            active     = 1'b0;
            exp_pc     = '0;
            halted_exp = 1'b0;
            stale      = 1'b1;
        end else if (flush) begin
            sb.delete();
            active     = 1'b1;
            exp_pc     = st ? sa : ra;
            halted_exp = 1'b0;
            stale      = 1'b1;
        end else if (vld && !stale) begin
            e.instr = mem_word(resp_addr);
            e.pc4   = resp_addr + 32'd4;
            sb.push_back(e);
            exp_pc = resp_addr + 32'd4;
            if (e.instr == 32'hFC00_0000) halted_exp = 1'b1;
        end
        if (!rst && imemReq) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = imemAddr;
            stale     = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit rdy);
        repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int idx;
        resetN = 1'b0; start = 1'b0; startAddress = '0; redirect = 1'b0;
        redirectAddr = '0; imemValid = 1'b0; imemData = '0; instReady = 1'b0;

        //                rst   st    rd    a             vld   data             rdy  | req  addr          val  cnt   halt  instr            pc4
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,           1'b0,  1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h100,      1'b1, 32'h5555,        1'b0,  1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h5555,        1'b0,  1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h100,      1'b0, 32'h0,           1'b0,  1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,           1'b0,  1'b1, 32'h100,      1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1111_0001,   1'b0,  1'b0, 32'h100,      1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,           1'b0,  1'b1, 32'h104,      1'b1, 3'd1, 1'b0, 32'h1111_0001,   32'h104));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1111_0002,   1'b1,  1'b0, 32'h104,      1'b1, 3'd1, 1'b0, 32'h1111_0001,   32'h104));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h400,      1'b0, 32'h0,           1'b0,  1'b0, 32'h108,      1'b1, 3'd1, 1'b0, 32'h1111_0002,   32'h108));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,           1'b0,  1'b1, 32'h400,      1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFC00_0000,   1'b0,  1'b0, 32'h400,      1'b0, 3'd0, 1'b0, 32'h0,           32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,           1'b0,  1'b0, 32'h404,      1'b1, 3'd1, 1'b1, 32'hFC00_0000,   32'h404));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 32'h0,           1'b0,  1'b0, 32'h404,      1'b1, 3'd1, 1'b1, 32'hFC00_0000,   32'h404));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,           1'b0,  1'b1, 32'h200,      1'b0, 3'd0, 1'b0, 32'h0,           32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            resetN       = !vecs[i].rst;
            start        = vecs[i].st;
            startAddress = vecs[i].a;
            redirect     = vecs[i].rd;
            redirectAddr = vecs[i].a;
            imemValid    = vecs[i].vld;
            imemData     = vecs[i].data;
            instReady    = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_imemReq", i), imemReq, vecs[i].e_req);
            check($sformatf("vec%0d_imemAddr", i), imemAddr, vecs[i].e_addr);
            check($sformatf("vec%0d_instValid", i), instValid, vecs[i].e_valid);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].e_halt);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_instruction", i), instruction, vecs[i].e_instr);
                check($sformatf("vec%0d_pcPlus4", i), pcPlus4, vecs[i].e_pc4);
            end
        end

        // Basic stream, latency 1, decode always ready
        do_reset(4);
        lat  = 1;
        base = n_req;
        n_pop = 0;
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        run(30, 1'b1);
        check("stream_pops", n_pop, 14);
        check("stream_reqs", n_req - base, 15);
        check("stream_first_addr", req_log[base], 32'h100);

        // Backpressure: fill to DEPTH, then one pop allows exactly one request
        do_reset(4);
        base = n_req;
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        run(12, 1'b0);
        check("bp_reqs_full", n_req - base, 4);
        check("bp_count_full", count, 4);
        check("bp_req_low", imemReq, 0);
        run(1, 1'b1);
        run(6, 1'b0);
        check("bp_reqs_after_pop", n_req - base, 5);
        check("bp_count_refill", count, 4);

        // Redirect one cycle after a request, latency 3: stale response dropped
        do_reset(4);
        lat = 3;
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        run(9, 1'b0);
        check("wr_prefill_count", count, 2);
        idx = req_log.size();
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wr_flush_count", count, 0);
        run(10, 1'b1);
        check("wr_req_seen", req_log.size() > idx, 1);
        if (req_log.size() > idx) check("wr_target", req_log[idx], 32'h400);

        // Redirect coincident with a response and a pop
        do_reset(4);
        lat = 1;
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        run(3, 1'b0);
        check("co_count_before", count, 1);
        idx = req_log.size();
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
        check("co_valid_in", imemValid, 1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("co_count_after", count, 0);
        run(4, 1'b0);
        check("co_req_seen", req_log.size() > idx, 1);
        if (req_log.size() > idx) check("co_target", req_log[idx], 32'h400);

        // Halt word at 0x108, then redirect resumes fetch
        do_reset(4);
        lat       = 1;
        halt_addr = 32'h108;
        base      = n_req;
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        run(15, 1'b1);
        check("halt_flag", halted, 1);
        check("halt_reqs", n_req - base, 3);
        check("halt_req_low", imemReq, 0);
        halt_addr = 32'hDEAD_0000;
        idx = req_log.size();
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("halt_cleared", halted, 0);
        run(6, 1'b1);
        check("halt_resume_seen", req_log.size() > idx, 1);
        if (req_log.size() > idx) check("halt_resume_addr", req_log[idx], 32'h200);

        // Address wrap, then reset while a response is outstanding
        do_reset(4);
        lat = 3;
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        run(5, 1'b0);
        check("wrap_pc4", pcPlus4, 0);
        check("wrap_addr", imemAddr, 0);
        check("wrap_req", imemReq, 1);
        do_reset(2);
        run(3, 1'b0);
        check("late_count", count, 0);
        check("late_halted", halted, 0);
        check("late_valid", instValid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
